rx_stat_counters: RTL
=====================

Name: rx_stat_counters

Overview:
- Parametrised receive-statistics counter bank for the 10G MAC rx_engine.
- Consumes the per-cycle increment-pulse vector from the rx statistics pulse generator and accumulates each pulse into a CNT_WIDTH counter.
- The frame-byte counter advances by a per-cycle byte count.
- Exposes a req/ack host read port with optional clear-on-read, a global clear, selectable wrap or saturate mode, and sticky per-counter overflow flags.

Parameters:
- NUM_STATS, 18, number of counters (index 0..NUM_STATS-1)
- CNT_WIDTH, 32, width of every counter and of rd_data
- BYTE_IDX, 17, index of the counter that adds byte_count instead of 1
- BYTE_INC_WIDTH, 4, width of byte_count (max legal value 8)
- ADDR_WIDTH, 5, width of rd_addr; must satisfy 2**ADDR_WIDTH >= NUM_STATS
- SATURATE, 0, 0 = counters wrap, 1 = counters stick at all-ones
- CLEAR_ON_READ, 1, 1 = a successful read zeroes the counter read

Ports:
- rxclk  in  1  receive clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- stat_inc  in  NUM_STATS  increment pulses, one bit per counter, sampled every cycle
- byte_count  in  BYTE_INC_WIDTH  bytes to add to counter BYTE_IDX when stat_inc[BYTE_IDX]=1
- clr_all  in  1  synchronous clear of all counters and overflow flags
- rd_req  in  1  read request, held high until rd_ack is seen
- rd_addr  in  ADDR_WIDTH  counter index, stable while rd_req is high
- rd_ack  out  1  one-cycle pulse; rd_data and rd_err are valid in that cycle
- rd_data  out  CNT_WIDTH  counter value captured at acceptance
- rd_err  out  1  rd_addr >= NUM_STATS
- ovf  out  NUM_STATS  sticky overflow/saturation flags

Behaviour:
- Reset (reset=0, asynchronous):
  - all counters = 0, ovf = 0, rd_ack = 0, rd_data = 0, rd_err = 0.
  - FSM = IDLE.
- Increment:
  - Every cycle, counter i += 1 if stat_inc[i]=1.
  - Counter BYTE_IDX instead adds zero-extended byte_count; byte_count = 0 is a legal no-op.
  - The sum is computed in CNT_WIDTH+1 bits.
  - If the carry is set:
    - SATURATE=0: keep the low CNT_WIDTH bits.
    - SATURATE=1: load all-ones.
    - In both modes, set ovf[i].
  - An increment to a counter already at all-ones with SATURATE=1 also sets ovf[i].
- Read FSM:
  - IDLE: rd_req=1 -> capture and go to ACK.
    - Capture: rd_data <= counter[rd_addr] (pre-increment value of that cycle); rd_err <= 0.
    - If rd_addr >= NUM_STATS: rd_data <= 0, rd_err <= 1, no counter is touched.
  - ACK: rd_ack=1 for exactly one cycle; go to WAIT_REL.
  - WAIT_REL: stay until rd_req=0, then go to IDLE. The requester must drop rd_req after seeing rd_ack.
  - Latency: rd_ack rises one cycle after the edge that samples rd_req high in IDLE. Minimum request spacing is 3 cycles.
  - rd_data and rd_err hold their value until the next capture.
- Clear-on-read (CLEAR_ON_READ=1, valid address):
  - At the capture edge the counter loads only that cycle's increment (0, 1 or byte_count). No event is lost.
  - ovf[rd_addr] is cleared at the same edge, unless that cycle's increment itself overflows (impossible from 0).
- CLEAR_ON_READ=0: the read has no side effect on counters or ovf.
- clr_all=1:
  - All counters <= 0 and ovf <= 0; same-cycle stat_inc pulses are discarded.
  - clr_all has priority over a coincident clear-on-read capture. rd_data still captures the pre-clear value.
  - clr_all does not affect the read FSM.
- Reset asserted mid-read: FSM returns to IDLE and rd_ack drops immediately. The requester must re-issue.
- All NUM_STATS counters update in parallel every cycle; there is no arbitration.

Decomposition:
- Package rx_stat_pkg:
  - counter index constants: STAT_GOOD_FRAMES=0, STAT_FCS_ERR=1, STAT_BCAST=2, STAT_MCAST=3, STAT_LEN_64=4 … STAT_LEN_1024_MAX=9, STAT_CTRL=10, STAT_LEN_RANGE_ERR=11, STAT_PAUSE=12, STAT_UNSUP_OPCODE=13, STAT_OVERSIZE=14, STAT_UNDERSIZE=15, STAT_FRAGMENT=16, STAT_BYTES=17.
  - FSM state encoding: IDLE, ACK, WAIT_REL.
- Sub-module rx_stat_cnt_cell: one counter with inc amount, clear, load-inc, SATURATE handling and ovf flag. It is instantiated NUM_STATS times by generate; the top level holds the read FSM and read mux.

Test Plan:
- Reset, then pulse stat_inc[0] for 5 cycles and read addr 0 -> rd_ack 1 cycle after sampling, rd_data=5, rd_err=0; a second read returns 0 (CLEAR_ON_READ=1).
- stat_inc[17]=1 for 3 cycles with byte_count 8, 8, 3, then read addr 17 -> rd_data=19.
- CNT_WIDTH=8, 257 pulses on counter 4:
  - SATURATE=0: read -> 1, ovf[4]=1 before the read and 0 after it.
  - SATURATE=1: read -> 255.
- Counter 2 = 10 with stat_inc[2]=1 in the capture cycle -> rd_data=10, counter becomes 1, next read = 1.
- rd_addr=20 with NUM_STATS=18 -> rd_ack with rd_err=1, rd_data=0; all counters unchanged.
- clr_all in the same cycle as stat_inc=all-ones and as a read capture of addr 3 (value 7) -> rd_data=7, all counters read 0 afterwards, ovf=0.
- Additionally, drop reset during ACK -> rd_ack=0 immediately; after release the FSM is IDLE and a new read completes normally.

Source files
------------

// File: rtl/rx_stat_counters_pkg.sv
// Shared definitions for the rx statistics counter bank:
// counter index map and read FSM state encoding.
package rx_stat_pkg;

    localparam int STAT_GOOD_FRAMES   = 0;
    localparam int STAT_FCS_ERR       = 1;
    localparam int STAT_BCAST         = 2;
    localparam int STAT_MCAST         = 3;
    localparam int STAT_LEN_64        = 4;
    localparam int STAT_LEN_65_127    = 5;
    localparam int STAT_LEN_128_255   = 6;
    localparam int STAT_LEN_256_511   = 7;
    localparam int STAT_LEN_512_1023  = 8;
    localparam int STAT_LEN_1024_MAX  = 9;
    localparam int STAT_CTRL          = 10;
    localparam int STAT_LEN_RANGE_ERR = 11;
    localparam int STAT_PAUSE         = 12;
    localparam int STAT_UNSUP_OPCODE  = 13;
    localparam int STAT_OVERSIZE      = 14;
    localparam int STAT_UNDERSIZE     = 15;
    localparam int STAT_FRAGMENT      = 16;
    localparam int STAT_BYTES         = 17;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_REL = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rx_stat_counters_if.sv
// Host read port of the rx statistics counter bank (req/ack).
interface rx_stat_counters_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ack;
    logic [CNT_WIDTH-1:0]  rd_data;
    logic                  rd_err;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data,
        input  rd_err
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data,
        output rd_err
    );

endinterface

// File: rtl/rx_stat_cnt_cell.sv
// One statistics counter: add, clear, clear-on-read load,
// wrap or saturate, and a sticky overflow flag.
module rx_stat_cnt_cell
    import rx_stat_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 4,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 rxclk,
    input  logic                 reset,
    input  logic [INC_WIDTH-1:0] inc_i,
    input  logic                 clr_i,
    input  logic                 load_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, base;
    logic [CNT_WIDTH:0]   sum;
    logic                 ovf_q, ovf_d;

    always_comb begin
        // a clear-on-read starts from zero so that cycle's event survives
        base  = load_i ? '0 : cnt_q;
        sum   = {1'b0, base} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_i};
        cnt_d = sum[CNT_WIDTH-1:0];
        ovf_d = load_i ? 1'b0 : ovf_q;
        if (sum[CNT_WIDTH]) begin
            ovf_d = 1'b1;
            if (SATURATE) begin
                cnt_d = '1;
            end
        end
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/rx_stat_counters.sv
// Receive statistics counter bank: parallel counter cells plus
// a req/ack read FSM with optional clear-on-read.
module rx_stat_counters
    import rx_stat_pkg::*;
#(
    parameter int NUM_STATS      = 18,
    parameter int CNT_WIDTH      = 32,
    parameter int BYTE_IDX       = 17,
    parameter int BYTE_INC_WIDTH = 4,
    parameter int ADDR_WIDTH     = 5,
    parameter int SATURATE       = 0,
    parameter int CLEAR_ON_READ  = 1
) (
    input  logic                      rxclk,
    input  logic                      reset,
    input  logic [NUM_STATS-1:0]      stat_inc,
    input  logic [BYTE_INC_WIDTH-1:0] byte_count,
    input  logic                      clr_all,
    rx_stat_counters_if.slave         rd,
    output logic [NUM_STATS-1:0]      ovf
);

    rd_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_err_q, rd_err_d;
    logic [CNT_WIDTH-1:0] sel;
    logic                 capture;
    logic                 addr_ok;

    logic [BYTE_INC_WIDTH-1:0] inc_amt [NUM_STATS];
    logic [CNT_WIDTH-1:0]      cnt     [NUM_STATS];
    logic [NUM_STATS-1:0]      load;

    assign capture = (state_q == IDLE) && rd.rd_req;
    assign addr_ok = int'(rd.rd_addr) < NUM_STATS;

    for (genvar g = 0; g < NUM_STATS; g++) begin : g_cell
        if (g == BYTE_IDX) begin : g_byte
            assign inc_amt[g] = stat_inc[g] ? byte_count : '0;
        end else begin : g_evt
            assign inc_amt[g] = BYTE_INC_WIDTH'(stat_inc[g]);
        end

        assign load[g] = (CLEAR_ON_READ != 0) && capture
                         && (rd.rd_addr == ADDR_WIDTH'(g));

        rx_stat_cnt_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (BYTE_INC_WIDTH),
            .SATURATE  (SATURATE != 0)
        ) u_cell (
            .rxclk  (rxclk),
            .reset  (reset),
            .inc_i  (inc_amt[g]),
            .clr_i  (clr_all),
            .load_i (load[g]),
            .cnt_o  (cnt[g]),
            .ovf_o  (ovf[g])
        );
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_STATS; i++) begin
            if (rd.rd_addr == ADDR_WIDTH'(i)) begin
                sel = cnt[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        unique case (state_q)
            IDLE: begin
                if (rd.rd_req) begin
                    rd_data_d = addr_ok ? sel : '0;
                    rd_err_d  = !addr_ok;
                    state_d   = ACK;
                end
            end
            ACK: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!rd.rd_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign rd.rd_ack  = (state_q == ACK);
    assign rd.rd_data = rd_data_q;
    assign rd.rd_err  = rd_err_q;

endmodule
